// File: rtl/geofence_pkg.sv
// Constants, feeder FSM states and the point payload shared by the geofence blocks.
package geofence_pkg;

  localparam int unsigned COORD_W       = 10;
  localparam int unsigned PTS_PER_FRAME = 7;
  localparam int unsigned NUM_FRAMES    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } feed_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/geofence_frame_buf.sv
// Two-frame point store: fills one frame while the other is read, tracks committed frames.
module geofence_frame_buf
  import geofence_pkg::*;
#(
  parameter  int unsigned PTS   = PTS_PER_FRAME,
  localparam int unsigned IDX_W = (PTS > 1) ? $clog2(PTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  point_t           wr_pt_i,
  input  logic             rel_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output point_t           rd_pt_o,
  output logic [1:0]       full_cnt_o
);

  point_t           mem_q [NUM_FRAMES][PTS];
  logic             wr_frame_q;
  logic             rd_frame_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [1:0]       full_cnt_q;
  logic             commit_c;

  // The last point of a frame makes the whole frame visible to the reader.
  assign commit_c = wr_en_i && (wr_idx_q == IDX_W'(PTS - 1));

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_frame_q][wr_idx_q] <= wr_pt_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_frame_q <= 1'b0;
      rd_frame_q <= 1'b0;
      wr_idx_q   <= '0;
      full_cnt_q <= '0;
    end else begin
      if (wr_en_i) begin
        if (commit_c) begin
          wr_idx_q   <= '0;
          wr_frame_q <= ~wr_frame_q;
        end else begin
          wr_idx_q <= wr_idx_q + IDX_W'(1);
        end
      end
      if (rel_en_i) begin
        rd_frame_q <= ~rd_frame_q;
      end
      case ({commit_c, rel_en_i})
        2'b10:   full_cnt_q <= full_cnt_q + 2'd1;
        2'b01:   full_cnt_q <= full_cnt_q - 2'd1;
        default: full_cnt_q <= full_cnt_q;
      endcase
    end
  end

  assign rd_pt_o    = mem_q[rd_frame_q][rd_idx_i];
  assign full_cnt_o = full_cnt_q;

endmodule

// File: rtl/geofence_feeder.sv
// Packs incoming points into frames and plays each frame to the geofence, holding the
// next one until the geofence reports a result or the wait budget runs out.
module geofence_feeder #(
  parameter int unsigned COORD_W  = geofence_pkg::COORD_W,
  parameter int unsigned PTS      = geofence_pkg::PTS_PER_FRAME,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               out_vld,
  output logic               out_first,
  input  logic               fence_valid,
  output logic               timeout_err,
  output logic [15:0]        frames_sent
);

  import geofence_pkg::*;

  localparam int unsigned IDX_W  = (PTS > 1) ? $clog2(PTS) : 1;
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  feed_state_e        state_q, state_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d, rd_addr_c;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               vld_q, vld_d;
  logic               first_q, first_d;
  logic               tmo_q, tmo_d;
  logic [15:0]        frames_q, frames_d;
  logic               accept_c;
  logic               release_c;
  logic [1:0]         full_cnt;
  point_t             wr_pt;
  point_t             rd_pt;

  assign in_ready = (full_cnt < 2'd2);
  assign accept_c = in_valid && in_ready;
  assign wr_pt    = '{x: in_x, y: in_y};

  // Read one point ahead so X/Y can be registered straight from the buffer.
  assign rd_addr_c = (state_q == SEND) ? rd_idx_q + IDX_W'(1) : '0;

  geofence_frame_buf #(
    .PTS (PTS)
  ) u_frame_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (accept_c),
    .wr_pt_i    (wr_pt),
    .rel_en_i   (release_c),
    .rd_idx_i   (rd_addr_c),
    .rd_pt_o    (rd_pt),
    .full_cnt_o (full_cnt)
  );

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    wait_d    = wait_q;
    x_d       = x_q;
    y_d       = y_q;
    vld_d     = 1'b0;
    first_d   = 1'b0;
    tmo_d     = 1'b0;
    frames_d  = frames_q;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_cnt != 2'd0) begin
          state_d  = SEND;
          rd_idx_d = '0;
          vld_d    = 1'b1;
          first_d  = 1'b1;
          x_d      = rd_pt.x;
          y_d      = rd_pt.y;
        end
      end
      SEND: begin
        if (rd_idx_q == IDX_W'(PTS - 1)) begin
          state_d = WAIT;
          wait_d  = '0;
        end else begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
          vld_d    = 1'b1;
          x_d      = rd_pt.x;
          y_d      = rd_pt.y;
        end
      end
      WAIT: begin
        // A real result wins over a timeout landing on the same edge.
        if (fence_valid) begin
          release_c = 1'b1;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          release_c = 1'b1;
          tmo_d     = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (release_c) begin
          state_d  = IDLE;
          frames_d = frames_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_idx_q <= '0;
      wait_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      tmo_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      wait_q   <= wait_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
      tmo_q    <= tmo_d;
      frames_q <= frames_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign out_vld     = vld_q;
  assign out_first   = first_q;
  assign timeout_err = tmo_q;
  assign frames_sent = frames_q;

endmodule
